procyon_ieu_wb: RTL



---
 rtl/procyon_ieu_wb_pkg.sv | 17 +
 rtl/procyon_ieu_wb_if.sv | 33 +++
 rtl/procyon_ieu_wb_queue.sv | 61 ++++++
 rtl/procyon_ieu_wb.sv | 98 +++++++++
 4 files changed

// File: rtl/procyon_ieu_wb_pkg.sv
// Shared defaults for the IEU writeback stage.
// The entry layout is {redirect, tag, addr, data}; it is declared where the widths are known.
package procyon_ieu_wb_pkg;

    localparam int unsigned PCYN_IEU_WB_DEFAULT_DEPTH      = 4;
    localparam int unsigned PCYN_IEU_WB_DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned PCYN_IEU_WB_DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned PCYN_IEU_WB_DEFAULT_ROB_WIDTH  = 5;

    // Width of one packed writeback entry
    function automatic int unsigned ieu_wb_entry_width(input int unsigned data_w,
                                                       input int unsigned addr_w,
                                                       input int unsigned tag_w);
        return data_w + addr_w + tag_w + 1;
    endfunction

endpackage

// File: rtl/procyon_ieu_wb_if.sv
// Common data bus port of the IEU writeback stage: head entry, request and grant.
interface procyon_ieu_wb_if
    import procyon_ieu_wb_pkg::*;
#(
    parameter int unsigned OPTN_DATA_WIDTH    = PCYN_IEU_WB_DEFAULT_DATA_WIDTH,
    parameter int unsigned OPTN_ADDR_WIDTH    = PCYN_IEU_WB_DEFAULT_ADDR_WIDTH,
    parameter int unsigned OPTN_ROB_IDX_WIDTH = PCYN_IEU_WB_DEFAULT_ROB_WIDTH
);
    logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data;
    logic [OPTN_ADDR_WIDTH-1:0]    o_cdb_addr;
    logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag;
    logic                          o_cdb_redirect;
    logic                          o_cdb_en;
    logic                          i_cdb_gnt;

    modport master (
        output o_cdb_data,
        output o_cdb_addr,
        output o_cdb_tag,
        output o_cdb_redirect,
        output o_cdb_en,
        input  i_cdb_gnt
    );

    modport slave (
        input  o_cdb_data,
        input  o_cdb_addr,
        input  o_cdb_tag,
        input  o_cdb_redirect,
        input  o_cdb_en,
        output i_cdb_gnt
    );
endinterface

// File: rtl/procyon_ieu_wb_queue.sv
// In-order circular queue holding writeback entries: storage, head/tail pointers and count.
module procyon_ieu_wb_queue
    import procyon_ieu_wb_pkg::*;
#(
    parameter int unsigned OPTN_ENTRY_WIDTH = 70,
    parameter int unsigned OPTN_DEPTH       = PCYN_IEU_WB_DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [OPTN_ENTRY_WIDTH-1:0]   i_entry,
    output logic [OPTN_ENTRY_WIDTH-1:0]   o_head,
    output logic [$clog2(OPTN_DEPTH):0]   o_count
);
    localparam int unsigned PTR_W = $clog2(OPTN_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]            r_head;
    logic [PTR_W-1:0]            r_tail;
    logic [CNT_W-1:0]            r_count;
    logic [OPTN_ENTRY_WIDTH-1:0] r_entries [OPTN_DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == CNT_W'(OPTN_DEPTH));
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);
    // When full, a push is only accepted if the head leaves in the same cycle
    assign w_push = i_push & ~i_flush & (~w_full | w_pop);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(OPTN_DEPTH); i++) r_entries[i] <= '0;
        end else if (w_push) begin
            r_entries[r_tail] <= i_entry;
        end
    end

    assign o_head  = r_entries[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/procyon_ieu_wb.sv
// IEU writeback stage: queues EX results and broadcasts them on the CDB in arrival order.
// Optional perf counters are built when PCYN_IEU_WB_PERF_EN is defined.
module procyon_ieu_wb
    import procyon_ieu_wb_pkg::*;
#(
    parameter int unsigned OPTN_DATA_WIDTH    = PCYN_IEU_WB_DEFAULT_DATA_WIDTH,
    parameter int unsigned OPTN_ADDR_WIDTH    = PCYN_IEU_WB_DEFAULT_ADDR_WIDTH,
    parameter int unsigned OPTN_ROB_IDX_WIDTH = PCYN_IEU_WB_DEFAULT_ROB_WIDTH,
    parameter int unsigned OPTN_IEU_WB_DEPTH  = PCYN_IEU_WB_DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_flush,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_data,
    input  logic [OPTN_ADDR_WIDTH-1:0]    i_addr,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag,
    input  logic                          i_redirect,
    input  logic                          i_valid,
    output logic                          o_stall,
    procyon_ieu_wb_if.master              cdb
`ifdef PCYN_IEU_WB_PERF_EN
    ,
    output logic [31:0]                   o_grant_count,
    output logic [31:0]                   o_stall_cycles
`endif
);
    localparam int unsigned ENTRY_W =
        ieu_wb_entry_width(OPTN_DATA_WIDTH, OPTN_ADDR_WIDTH, OPTN_ROB_IDX_WIDTH);
    localparam int unsigned CNT_W   = $clog2(OPTN_IEU_WB_DEPTH) + 1;

    typedef struct packed {
        logic                          redirect;
        logic [OPTN_ROB_IDX_WIDTH-1:0] tag;
        logic [OPTN_ADDR_WIDTH-1:0]    addr;
        logic [OPTN_DATA_WIDTH-1:0]    data;
    } ieu_wb_entry_t;

    if (OPTN_IEU_WB_DEPTH < 2 || (OPTN_IEU_WB_DEPTH & (OPTN_IEU_WB_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("OPTN_IEU_WB_DEPTH must be a power of two and at least 2");
    end

    ieu_wb_entry_t    w_entry;
    ieu_wb_entry_t    w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_cdb_en;
    logic             w_pop;

    assign w_entry = '{redirect: i_redirect, tag: i_tag, addr: i_addr, data: i_data};

    procyon_ieu_wb_queue #(
        .OPTN_ENTRY_WIDTH (ENTRY_W),
        .OPTN_DEPTH       (OPTN_IEU_WB_DEPTH)
    ) u_queue (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_flush (i_flush),
        .i_push  (i_valid),
        .i_pop   (w_pop),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_cdb_en = (w_count != '0);
    assign w_pop    = w_cdb_en & cdb.i_cdb_gnt;
    // Threshold leaves room for the result already in flight in EX
    assign o_stall  = (w_count >= CNT_W'(OPTN_IEU_WB_DEPTH - 1));

    assign cdb.o_cdb_en       = w_cdb_en;
    assign cdb.o_cdb_data     = w_head.data;
    assign cdb.o_cdb_addr     = w_head.addr;
    assign cdb.o_cdb_tag      = w_head.tag;
    assign cdb.o_cdb_redirect = w_head.redirect;

`ifdef PCYN_IEU_WB_PERF_EN
    logic [31:0] r_grant_count;
    logic [31:0] r_stall_cycles;

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_grant_count  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_pop & ~i_flush) r_grant_count <= r_grant_count + 32'd1;
            if (o_stall)          r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_grant_count  = r_grant_count;
    assign o_stall_cycles = r_stall_cycles;
`endif

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!n_rst)
        !(i_valid && !i_flush && (w_count == CNT_W'(OPTN_IEU_WB_DEPTH)) && !w_pop))
        else $error("procyon_ieu_wb: push while full without pop");

endmodule
